// File: rtl/record_unpacker.sv
// -----------------------------------------------------------------------------
// record_unpacker
//
// Receive-side counterpart of the record packer. Reassembles one record per
// frame of LANES+1 beats: beat 0 carries the header field (bar), beats
// 1..LANES fill the lane array (baz) MSB lane first. The finished record is
// presented with a valid/ready hold; framing violations discard the frame and
// pulse err for one cycle.
//
// Optional feature macro: RECORD_UNPACKER_PARITY_EN
//   When defined, the in_par port exists and every accepted beat is checked
//   for even parity. A frame with any bad beat runs to its normal end, then
//   pulses err instead of presenting a record.
//
// Parameters:
//   HDR_W   header width (must be <= LANE_W)
//   LANES   number of baz lanes
//   LANE_W  beat and lane width
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   beat present
//   in_ready   beat accepted when in_valid && in_ready (depends on state only)
//   in_data    beat payload
//   in_last    final beat of a frame
//   in_par     even-parity bit of in_data (parity build only)
//   out_valid  record available (registered)
//   out_ready  consumer accepts record
//   out_bar    header field (registered)
//   out_baz    lane array (registered)
//   err        one-cycle pulse after a discarded frame's offending beat
// -----------------------------------------------------------------------------
module record_unpacker #(
   parameter int HDR_W  = 8,
   parameter int LANES  = 8,
   parameter int LANE_W = 42
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANE_W-1:0]             in_data,
   input  logic                          in_last,
`ifdef RECORD_UNPACKER_PARITY_EN
   input  logic                          in_par,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [HDR_W-1:0]              out_bar,
   output logic [LANES-1:0][LANE_W-1:0]  out_baz,
   output logic                          err
);

   localparam int CNT_W = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES);

   typedef enum logic [1:0] {
      S_HEADER = 2'd0,
      S_BODY   = 2'd1,
      S_HOLD   = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [HDR_W-1:0]              bar_q, bar_d;
   logic [LANES-1:0][LANE_W-1:0]  baz_q, baz_d;
   logic                          err_q, err_d;
   logic                          bad_q, bad_d;
   logic                          accept;
   logic                          par_err;

`ifdef RECORD_UNPACKER_PARITY_EN
   assign par_err = (in_par != ^in_data);
`else
   assign par_err = 1'b0;
`endif

   // in_ready is a pure function of the registered state: no path from
   // out_ready, so a HOLD handshake only re-opens the input next cycle.
   assign in_ready  = (state_q != S_HOLD);
   assign out_valid = (state_q == S_HOLD);
   assign out_bar   = bar_q;
   assign out_baz   = baz_q;
   assign err       = err_q;
   assign accept    = in_valid && in_ready;

   // ---------------------------------------------------------------------------
   // Next-state and datapath capture
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bar_d   = bar_q;
      baz_d   = baz_q;
      err_d   = 1'b0;
      bad_d   = bad_q;

      case (state_q)
         S_HEADER: begin
            if (accept) begin
               bar_d = in_data[HDR_W-1:0];
               cnt_d = CNT_W'(1);
               bad_d = par_err;
               if (in_last) begin
                  // Single-beat frame: framing error wins, one err only.
                  err_d = 1'b1;
                  cnt_d = '0;
                  bad_d = 1'b0;
               end else begin
                  state_d = S_BODY;
               end
            end
         end

         S_BODY: begin
            if (accept) begin
               // Beat cnt lands in lane LANES-cnt (MSB lane first).
               for (int l = 0; l < LANES; l++) begin
                  if (l == LANES - int'(cnt_q)) begin
                     baz_d[l] = in_data;
                  end
               end
               if (cnt_q == LAST_CNT) begin
                  cnt_d = '0;
                  bad_d = 1'b0;
                  if (!in_last) begin
                     err_d   = 1'b1;
                     state_d = S_DRAIN;
                  end else if (bad_q || par_err) begin
                     err_d   = 1'b1;
                     state_d = S_HEADER;
                  end else begin
                     state_d = S_HOLD;
                  end
               end else if (in_last) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  bad_d   = 1'b0;
                  state_d = S_HEADER;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  bad_d = bad_q | par_err;
               end
            end
         end

         S_HOLD: begin
            if (out_ready) begin
               state_d = S_HEADER;
            end
         end

         S_DRAIN: begin
            // Already reported; swallow beats until the stray frame ends.
            if (accept && in_last) begin
               state_d = S_HEADER;
            end
         end

         default: begin
            state_d = S_HEADER;
            cnt_d   = '0;
            bad_d   = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HEADER;
         cnt_q   <= '0;
         bar_q   <= '0;
         baz_q   <= '0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bar_q   <= bar_d;
         baz_q   <= baz_d;
         err_q   <= err_d;
         bad_q   <= bad_d;
      end
   end

endmodule

// File: tb/tb_record_unpacker.sv
module tb_record_unpacker;

   localparam int HDR_W  = 8;
   localparam int LANES  = 8;
   localparam int LANE_W = 42;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          in_valid = 1'b0;
   logic                          in_ready;
   logic [LANE_W-1:0]             in_data = '0;
   logic                          in_last = 1'b0;
`ifdef RECORD_UNPACKER_PARITY_EN
   logic                          in_par = 1'b0;
`endif
   logic                          out_valid;
   logic                          out_ready = 1'b1;
   logic [HDR_W-1:0]              out_bar;
   logic [LANES-1:0][LANE_W-1:0]  out_baz;
   logic                          err;

   int total = 0;
   int bad   = 0;

   // Reference frame: fr[0] is the header beat, fr[1..LANES] the lane beats.
   logic [LANE_W-1:0] fr [LANES+1];

   record_unpacker #(.HDR_W(HDR_W), .LANES(LANES), .LANE_W(LANE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
`ifdef RECORD_UNPACKER_PARITY_EN
      .in_par    (in_par),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bar   (out_bar),
      .out_baz   (out_baz),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [LANE_W-1:0] d, input logic last, input logic flip);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
`ifdef RECORD_UNPACKER_PARITY_EN
      in_par   = (^d) ^ flip;
`else
      if (flip) begin end
`endif
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic rand_frame();
      for (int i = 0; i <= LANES; i++) fr[i] = LANE_W'({$urandom(), $urandom()});
   endtask

   // Sends fr[0..nb-1]; in_last on beat last_at, parity flipped on beat flip_at.
   task automatic send_frame(input int last_at, input int nb, input int flip_at);
      for (int i = 0; i < nb; i++) send_beat(fr[i], i == last_at, i == flip_at);
   endtask

   // Expected record from the spec: bar is the low header bits, lane l holds
   // beat LANES-l.
   task automatic check_record(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_err"},   64'(err),       64'd0);
      chk({tag, "_bar"},   64'(out_bar),   64'(fr[0][HDR_W-1:0]));
      for (int l = 0; l < LANES; l++)
         chk($sformatf("%s_baz%0d", tag, l), 64'(out_baz[l]), 64'(fr[LANES-l]));
   endtask

   task automatic release_record(input string tag);
      out_ready = 1'b1;
      step();
      chk({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_rel_ready"}, 64'(in_ready),  64'd1);
   endtask

   initial begin
      // Power-on reset.
      step();
      step();
      rst = 1'b0;
      step();
      chk("por_ready", 64'(in_ready),  64'd1);
      chk("por_valid", 64'(out_valid), 64'd0);
      chk("por_err",   64'(err),       64'd0);

      // Reset mid-BODY, beat 4 presented.
      rand_frame();
      send_frame(99, 4, 99);
      in_valid = 1'b1;
      in_data  = fr[4];
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_err",   64'(err),       64'd0);
      chk("rst_bar",   64'(out_bar),   64'd0);
      for (int l = 0; l < LANES; l++) chk($sformatf("rst_baz%0d", l), 64'(out_baz[l]), 64'd0);
      chk("rst_ready", 64'(in_ready),  64'd1);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      rand_frame();
      send_frame(LANES, LANES + 1, 99);
      check_record("post_rst");
      release_record("post_rst");

      // Nominal frame with fixed values.
      fr[0] = LANE_W'(42'h0A5);
      for (int k = 1; k <= LANES; k++) fr[k] = {10'h3FF, 32'(LANES - k)};
      out_ready = 1'b1;
      send_frame(LANES, LANES + 1, 99);
      check_record("nom");
      chk("nom_bar_const",  64'(out_bar),    64'h0A5);
      chk("nom_baz7_const", 64'(out_baz[7]), 64'h3FF00000007);
      chk("nom_ready_low",  64'(in_ready),   64'd0);
      step();
      chk("nom_valid_drop", 64'(out_valid),  64'd0);
      chk("nom_ready_back", 64'(in_ready),   64'd1);

      // Backpressure: record held 5 cycles while a new header is stalled.
      rand_frame();
      out_ready = 1'b0;
      send_frame(LANES, LANES + 1, 99);
      check_record("bp0");
      begin
         logic [LANE_W-1:0] nxt [LANES+1];
         for (int i = 0; i <= LANES; i++) nxt[i] = LANE_W'({$urandom(), $urandom()});
         in_valid = 1'b1;
         in_data  = nxt[0];
         in_last  = 1'b0;
`ifdef RECORD_UNPACKER_PARITY_EN
         in_par   = ^nxt[0];
`endif
         for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("bp_ready_c%0d", c), 64'(in_ready), 64'd0);
            check_record($sformatf("bp_c%0d", c));
         end
         out_ready = 1'b1;
         step();
         chk("bp_ready_rise", 64'(in_ready),  64'd1);
         chk("bp_valid_fall", 64'(out_valid), 64'd0);
         for (int i = 0; i <= LANES; i++) fr[i] = nxt[i];
         send_frame(LANES, LANES + 1, 99);
         check_record("bp_next");
         release_record("bp_next");
      end

      // Early last on beat 3.
      rand_frame();
      send_frame(3, 4, 99);
      chk("early_err",   64'(err),       64'd1);
      chk("early_valid", 64'(out_valid), 64'd0);
      step();
      chk("early_err_1cyc", 64'(err),       64'd0);
      chk("early_valid2",   64'(out_valid), 64'd0);
      rand_frame();
      send_frame(LANES, LANES + 1, 99);
      check_record("early_next");
      release_record("early_next");

      // Missing last: beat 8 without in_last, then two drained beats.
      rand_frame();
      send_frame(99, LANES + 1, 99);
      chk("miss_err",   64'(err),       64'd1);
      chk("miss_valid", 64'(out_valid), 64'd0);
      chk("miss_ready", 64'(in_ready),  64'd1);
      send_beat(LANE_W'($urandom()), 1'b0, 1'b0);
      chk("drain1_err",   64'(err),       64'd0);
      chk("drain1_valid", 64'(out_valid), 64'd0);
      send_beat(LANE_W'($urandom()), 1'b1, 1'b0);
      chk("drain2_err",   64'(err),       64'd0);
      chk("drain2_valid", 64'(out_valid), 64'd0);
      rand_frame();
      send_frame(LANES, LANES + 1, 99);
      check_record("miss_next");
      release_record("miss_next");

      // Parity flipped on beat 5.
      rand_frame();
      send_frame(LANES, LANES + 1, 5);
`ifdef RECORD_UNPACKER_PARITY_EN
      chk("par_err",   64'(err),       64'd1);
      chk("par_valid", 64'(out_valid), 64'd0);
      step();
      chk("par_err_1cyc", 64'(err),       64'd0);
      chk("par_valid2",   64'(out_valid), 64'd0);
      chk("par_ready",    64'(in_ready),  64'd1);
`else
      check_record("nopar");
      release_record("nopar");
`endif

      // Random frames with random consumer delay.
      for (int f = 0; f < 16; f++) begin
         int d;
         rand_frame();
         out_ready = 1'b0;
         send_frame(LANES, LANES + 1, 99);
         check_record($sformatf("rnd%0d", f));
         d = int'($urandom_range(0, 3));
         for (int c = 0; c < d; c++) begin
            step();
            chk($sformatf("rnd%0d_hold", f), 64'(out_valid), 64'd1);
         end
         release_record($sformatf("rnd%0d", f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/record_unpacker.md
# record_unpacker

Receive-side counterpart of the record packer. It accepts a framed stream of LANE_W-bit beats and reassembles one record per frame into a header field `bar` and a lane array `baz`. Field order matches the packed concatenation `{bar[7:0], baz[7:0][41:0]}`. It sits between the serial link and the port-expression consumers; frame checking and a valid/ready output hold are its only sequential logic.

## Interface

Parameters:
- HDR_W, default 8: header (`bar`) width; must be ≤ LANE_W.
- LANES, default 8: number of `baz` lanes.
- LANE_W, default 42: beat and lane width.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  LANE_W  beat payload.
- in_last  input  1  marks final beat of a frame.
- in_par  input  1  even-parity bit for in_data; present only with RECORD_UNPACKER_PARITY_EN.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts record.
- out_bar  output  HDR_W  header field.
- out_baz  output  [LANES-1:0][LANE_W-1:0]  lane array.
- err  output  1  one-cycle pulse on a discarded frame.

## Operation

- Frame: exactly LANES+1 beats.
  - Beat 0 is the header: out_bar ← in_data[HDR_W-1:0]; upper bits are ignored.
  - Beats 1..LANES fill out_baz[LANES-1] down to out_baz[0], MSB lane first.
  - in_last must be high on beat LANES only.
- Beat counter `cnt` spans 0..LANES, width clog2(LANES+1).
- States:
  - HEADER: in_ready=1. On accept: capture bar, cnt←1.
    - in_last=1 here → err, stay HEADER.
    - Otherwise → BODY.
  - BODY: in_ready=1. On accept: write lane LANES-cnt.
    - in_last=1 with cnt<LANES → err, → HEADER.
    - cnt==LANES and in_last=1 → HOLD.
    - cnt==LANES and in_last=0 → err, → DRAIN.
    - Otherwise cnt+1.
  - HOLD: in_ready=0, out_valid=1. out_bar/out_baz are stable. On out_ready → HEADER.
  - DRAIN: in_ready=1. Beats are discarded; on an accepted beat with in_last=1 → HEADER. No further err.
- A discarded frame never asserts out_valid. Partially written out_bar/out_baz contents are don't-care while out_valid=0.
- err is registered and high exactly one cycle, in the cycle after the offending beat is accepted.
- Reset, anywhere including mid-frame or in HOLD:
  - state HEADER, cnt=0.
  - out_valid=0, out_bar=0, out_baz all 0, err=0.
  - in_ready=1 once rst deasserts.
  - Partial frame is lost; the next accepted beat is treated as a header.

## Timing

- Output latency: out_valid rises the cycle after the final beat is accepted.
- Minimum frame period: LANES+2 cycles, since in_ready=0 for at least one HOLD cycle.
- A HOLD handshake in cycle N means in_ready=1 in cycle N+1. There is no same-cycle pass-through.
- in_valid without in_ready (only in HOLD) is simply stalled. The upstream side must hold its beat.
- in_ready depends only on state: registered, no combinational path from out_ready.
- out_valid, out_bar, out_baz and err are all registered outputs.

## Configuration

- RECORD_UNPACKER_PARITY_EN defined:
  - in_par port exists. Each accepted beat is checked: mismatch when in_par != ^in_data.
  - Any mismatch marks the frame bad. The frame still runs to its normal end (last-beat rules unchanged).
  - A bad frame pulses err the cycle after its final beat, → HEADER, and never enters HOLD.
  - At most one err per frame; a framing error takes precedence.
  - The bad flag clears on HEADER entry and on reset.
- RECORD_UNPACKER_PARITY_EN undefined: in_par absent, no parity check, behaviour as above.

## Test plan

- Reset values: assert rst mid-BODY (beat 4). Require out_valid=0, err=0, out_bar=0, out_baz=0, in_ready=1. A fresh 9-beat frame after reset completes normally.
- Nominal frame: header 0x000000000A5, lanes 7..0 = 0x3FF_0000_0007 … 0x3FF_0000_0000, last on beat 8, out_ready=1.
  - Require out_valid high exactly one cycle later, with out_bar=0xA5 and out_baz[7]=0x3FF00000007.
  - Require in_ready low for that single cycle.
- Backpressure: hold out_ready=0 for 5 cycles after completion. Require out_valid and data stable, in_ready=0, and a stalled new header not consumed. After out_ready=1, in_ready rises the next cycle.
- Early last: in_last on beat 3. Require err pulse one cycle later, no out_valid, and the next beat accepted as header.
- Missing last: beat 8 without in_last. Require err pulse and DRAIN. The next two beats are dropped (second has last). The following 9-beat frame yields out_valid with its own data.
- Parity (macro defined): flip in_par on beat 5. Require err pulse the cycle after beat 8 and no out_valid. Same stimulus with the macro undefined (in_par removed) yields a normal record.
